// File: rtl/muldiv_unit.sv
// ============================================================================
// muldiv_unit : iterative multiply/divide unit owning the HI/LO register pair
//               (radix-2 shift-add multiply, restoring divide, signed fix-up)
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [2:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             flush_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  localparam logic [2:0] OP_MTHI = 3'd4;
  localparam logic [2:0] OP_MTLO = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2
  } state_t;

  state_t             state_q;
  logic [CW-1:0]      cnt_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [WIDTH-1:0]   x_q;      // shifting operand: multiplier or dividend
  logic [WIDTH-1:0]   y_q;      // fixed operand: multiplicand or divisor
  logic               is_div_q;
  logic               qneg_q;
  logic               rneg_q;
  logic               dz_q;
  logic               busy_q;
  logic               done_q;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;

  logic               start_signed;
  logic [WIDTH-1:0]   abs_a;
  logic [WIDTH-1:0]   abs_b;

  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     div_shift;
  logic               div_ok;
  logic [WIDTH-1:0]   div_diff;
  logic [WIDTH-1:0]   div_rem;
  logic [2*WIDTH-1:0] div_next;
  logic [2*WIDTH-1:0] acc_d;
  logic [WIDTH-1:0]   x_d;

  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quot_fix;
  logic [WIDTH-1:0]   rem_fix;

  always_comb begin
    start_signed = ~op_i[0];
    abs_a = (start_signed && a_i[WIDTH-1]) ? (~a_i + 1'b1) : a_i;
    abs_b = (start_signed && b_i[WIDTH-1]) ? (~b_i + 1'b1) : b_i;

    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (x_q[0] ? {1'b0, y_q} : {(WIDTH+1){1'b0}});
    mul_next = {mul_sum, acc_q[WIDTH-1:1]};

    // Remainder shifted left with the next dividend bit; a zero divisor always
    // "succeeds", which yields an all-ones quotient and remainder = dividend.
    div_shift = {acc_q[2*WIDTH-1:WIDTH], x_q[WIDTH-1]};
    div_ok    = (div_shift >= {1'b0, y_q});
    div_diff  = div_shift[WIDTH-1:0] - y_q;
    div_rem   = div_ok ? div_diff : div_shift[WIDTH-1:0];
    div_next  = {div_rem, acc_q[WIDTH-2:0], div_ok};

    acc_d = is_div_q ? div_next : mul_next;
    x_d   = is_div_q ? (x_q << 1) : (x_q >> 1);

    prod_fix = qneg_q ? (~acc_q + 1'b1) : acc_q;
    quot_fix = (qneg_q && !dz_q) ? (~acc_q[WIDTH-1:0] + 1'b1) : acc_q[WIDTH-1:0];
    rem_fix  = rneg_q ? (~acc_q[2*WIDTH-1:WIDTH] + 1'b1) : acc_q[2*WIDTH-1:WIDTH];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      x_q      <= '0;
      y_q      <= '0;
      is_div_q <= 1'b0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      dz_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start_i && !flush_i) begin
            if (!op_i[2]) begin
              is_div_q <= op_i[1];
              qneg_q   <= start_signed & (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
              rneg_q   <= start_signed & op_i[1] & a_i[WIDTH-1];
              dz_q     <= op_i[1] & (b_i == '0);
              x_q      <= op_i[1] ? abs_a : abs_b;
              y_q      <= op_i[1] ? abs_b : abs_a;
              acc_q    <= '0;
              cnt_q    <= CW'(WIDTH - 1);
              busy_q   <= 1'b1;
              state_q  <= ST_CALC;
            end else if (op_i == OP_MTHI) begin
              hi_q <= b_i;
            end else if (op_i == OP_MTLO) begin
              lo_q <= b_i;
            end
          end
        end
        ST_CALC: begin
          if (flush_i) begin
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end else begin
            acc_q <= acc_d;
            x_q   <= x_d;
            if (cnt_q == '0) begin
              state_q <= ST_FIX;
            end else begin
              cnt_q <= cnt_q - 1'b1;
            end
          end
        end
        ST_FIX: begin
          if (!flush_i) begin
            if (is_div_q) begin
              hi_q <= rem_fix;
              lo_q <= quot_fix;
            end else begin
              hi_q <= prod_fix[2*WIDTH-1:WIDTH];
              lo_q <= prod_fix[WIDTH-1:0];
            end
            done_q <= 1'b1;
          end
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy_o = busy_q;
  assign done_o = done_q;
  assign hi_o   = hi_q;
  assign lo_o   = lo_q;

endmodule

`default_nettype wire

// File: tb/tb_muldiv_unit.sv
// ============================================================================
// tb_muldiv_unit : scoreboard bench for muldiv_unit (WIDTH=32 and WIDTH=8)
// Revision       : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        start32 = 1'b0, flush32 = 1'b0;
  logic [2:0]  op32 = 3'd6;
  logic [31:0] a32 = '0, b32 = '0;
  logic        busy32, done32;
  logic [31:0] hi32, lo32;

  logic        start8 = 1'b0, flush8 = 1'b0;
  logic [2:0]  op8 = 3'd6;
  logic [7:0]  a8 = '0, b8 = '0;
  logic        busy8, done8;
  logic [7:0]  hi8, lo8;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int t0_32 = 0;
  int t0_8 = 0;

  logic [63:0] q32[$];
  logic [15:0] q8[$];

  muldiv_unit #(.WIDTH(32)) u_dut32 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start32), .op_i(op32),
    .a_i(a32), .b_i(b32), .flush_i(flush32),
    .busy_o(busy32), .done_o(done32), .hi_o(hi32), .lo_o(lo32)
  );

  muldiv_unit #(.WIDTH(8)) u_dut8 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start8), .op_i(op8),
    .a_i(a8), .b_i(b8), .flush_i(flush8),
    .busy_o(busy8), .done_o(done8), .hi_o(hi8), .lo_o(lo8)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard monitors: each DONE pulse pops and compares the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && done32) begin
      if (q32.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL done32_unexpected: got HI:LO 0x%0h expected no DONE", {hi32, lo32});
      end else begin
        check("result32", {hi32, lo32}, q32.pop_front());
      end
    end
    if (rst_n && done8) begin
      if (q8.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL done8_unexpected: got HI:LO 0x%0h expected no DONE", {hi8, lo8});
      end else begin
        check("result8", {48'd0, hi8, lo8}, {48'd0, q8.pop_front()});
      end
    end
  end

  task automatic issue32(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input bit push, input logic [63:0] exp);
    @(negedge clk);
    start32 = 1'b1; op32 = op; a32 = a; b32 = b;
    if (push) q32.push_back(exp);
    @(posedge clk); #1;
    start32 = 1'b0; op32 = 3'd6;
    t0_32 = cyc;
    check("busy32_after_start", {63'd0, busy32}, 64'd1);
  endtask

  task automatic wait32();
    forever begin
      if (done32 || (cyc - t0_32) > 60) break;
      @(posedge clk); #1;
    end
    check("latency32", 64'(cyc - t0_32), 64'd33);
    check("busy32_at_done", {63'd0, busy32}, 64'd0);
  endtask

  task automatic run32(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] ehi, input logic [31:0] elo);
    issue32(op, a, b, 1'b1, {ehi, elo});
    wait32();
  endtask

  task automatic run8(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                      input logic [7:0] ehi, input logic [7:0] elo);
    @(negedge clk);
    start8 = 1'b1; op8 = op; a8 = a; b8 = b;
    q8.push_back({ehi, elo});
    @(posedge clk); #1;
    start8 = 1'b0; op8 = 3'd6;
    t0_8 = cyc;
    forever begin
      if (done8 || (cyc - t0_8) > 30) break;
      @(posedge clk); #1;
    end
    check("latency8", 64'(cyc - t0_8), 64'd9);
  endtask

  task automatic mt32(input logic [2:0] op, input logic [31:0] b);
    @(negedge clk);
    start32 = 1'b1; op32 = op; b32 = b;
    @(posedge clk); #1;
    start32 = 1'b0; op32 = 3'd6;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("rst_busy", {63'd0, busy32}, 64'd0);
    check("rst_done", {63'd0, done32}, 64'd0);
    check("rst_hilo", {hi32, lo32}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // MTHI makes HI non-zero so the mid-operation reset has something to clear
    mt32(3'd4, 32'hDEAD_BEEF);
    check("mthi_idle", {32'd0, hi32}, 64'hDEAD_BEEF);
    check("mthi_no_busy", {63'd0, busy32}, 64'd0);
    issue32(3'd0, 32'h0000_0005, 32'h0000_0007, 1'b0, 64'd0);
    repeat (10) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_busy", {63'd0, busy32}, 64'd0);
    check("async_rst_hilo", {hi32, lo32}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    check("post_rst_idle", {62'd0, busy32, done32}, 64'd0);

    run32(3'd0, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    run32(3'd1, 32'hFFFF_FFFE, 32'h0000_0003, 32'h0000_0002, 32'hFFFF_FFFA);
    run32(3'd2, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run32(3'd3, 32'h0000_0007, 32'h0000_0000, 32'h0000_0007, 32'hFFFF_FFFF);
    run32(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
    run32(3'd2, 32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFFF);

    // MTHI while busy is dropped; HI/LO hold the old result until the FIX edge
    issue32(3'd1, 32'd6, 32'd7, 1'b1, {32'd0, 32'd42});
    repeat (3) @(posedge clk);
    mt32(3'd4, 32'h0000_1234);
    check("mthi_busy_ignored", {hi32, lo32}, {32'hFFFF_FFF9, 32'hFFFF_FFFF});
    wait32();
    run32(3'd3, 32'd100, 32'd7, 32'd2, 32'd14);

    mt32(3'd5, 32'h0000_0055);
    check("mtlo_idle", {hi32, lo32}, {32'd2, 32'h55});

    issue32(3'd1, 32'd3, 32'd5, 1'b0, 64'd0);
    repeat (4) @(posedge clk);
    @(negedge clk);
    flush32 = 1'b1;
    @(posedge clk); #1;
    flush32 = 1'b0;
    check("flush_busy", {63'd0, busy32}, 64'd0);
    check("flush_hilo", {hi32, lo32}, {32'd2, 32'h55});
    repeat (40) @(negedge clk);
    run32(3'd1, 32'd3, 32'd5, 32'd0, 32'd15);

    @(negedge clk);
    start32 = 1'b1; op32 = 3'd3; a32 = 32'd100; b32 = 32'd7; flush32 = 1'b1;
    @(posedge clk); #1;
    start32 = 1'b0; flush32 = 1'b0; op32 = 3'd6;
    check("flush_start_dropped", {63'd0, busy32}, 64'd0);
    repeat (40) @(negedge clk);
    check("flush_start_hilo", {hi32, lo32}, {32'd0, 32'd15});

    run8(3'd0, 8'h80, 8'h80, 8'h40, 8'h00);
    run8(3'd2, 8'h81, 8'h03, 8'hFF, 8'hD6);

    repeat (3) @(negedge clk);
    check("q32_drained", 64'(q32.size()), 64'd0);
    check("q8_drained", 64'(q8.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative multiply/divide unit owning the HI/LO register pair, parametrised in operand width. Replaces the single-cycle combinational multiply/divide in the execute stage with a multi-cycle shift-add / restoring-divide datapath. Adds signed handling, defined divide-by-zero results, a start/busy/done handshake and a flush for squashed instructions. Sits beside the ALU in EX; MFHI/MFLO read `HI`/`LO` directly, and the pipeline interlocks on `BUSY`.

## Interface
- `WIDTH`, 32, operand and HI/LO width; legal values are even numbers ≥ 4.
- `CLK`  in  1  clock; all state changes on the rising edge.
- `RST`  in  1  reset, asynchronous assert, active-low (0 = reset).
- `START`  in  1  request; sampled only when `BUSY`=0.
- `OP`  in  3  operation: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6/7 no-op.
- `A`  in  WIDTH  rs operand: multiplicand or dividend.
- `B`  in  WIDTH  rt operand: multiplier or divisor; also the MTHI/MTLO source.
- `FLUSH`  in  1  abort any in-flight operation.
- `BUSY`  out  1  operation in flight.
- `DONE`  out  1  one-cycle pulse when HI/LO have just been updated by a mul/div.
- `HI`  out  WIDTH  HI register.
- `LO`  out  WIDTH  LO register.

## Operation
- States: IDLE, CALC, FIX.
- IDLE, `START`=1, `FLUSH`=0, OP 0–3:
  - Latch operand magnitudes. Signed ops only: take the two's-complement absolute value.
  - Latch the result-sign flags:
    - quotient/product sign = sign(A) XOR sign(B);
    - remainder sign = sign(A).
  - Clear the 2·WIDTH accumulator; load iteration counter = WIDTH−1; go to CALC.
- IDLE, `START`=1, OP 4/5: write `B` into HI (MTHI) or LO (MTLO) on that edge. Stay IDLE; no `BUSY`, no `DONE`.
- OP 6/7, or `START`=0: no action.
- CALC, one iteration per cycle, WIDTH iterations:
  - Multiply: radix-2 shift-add on the unsigned magnitudes.
  - Divide: restoring division, one quotient bit per cycle.
  - Counter reaches 0 → go to FIX.
- FIX, one cycle:
  - Negate the product, or the quotient and remainder independently, per the sign flags (signed ops only).
  - Multiply: write HI = product[2W−1:W], LO = product[W−1:0].
  - Divide: write LO = quotient, HI = remainder.
  - Pulse `DONE`; go to IDLE.
- Divide by zero, decided result (iterations still run full length):
  - LO = all ones;
  - HI = A, unmodified, for both DIV and DIVU.
- Signed overflow (DIV of most-negative by −1): LO = most-negative value, HI = 0. This falls out of the magnitude algorithm and needs no special case.
- `START` while `BUSY`=1: ignored, including MTHI/MTLO. Software/interlock guarantees ordering.
- `FLUSH`=1 in CALC or FIX: go to IDLE on that edge. HI/LO unchanged, no `DONE`.
- `FLUSH`=1 with `START` in IDLE: the flush wins and the request is dropped.
- `HI`/`LO` hold their previous values for the whole operation; the only update is at the FIX edge.

## Timing
- Reset: state IDLE, `BUSY`=0, `DONE`=0, `HI`=0, `LO`=0, accumulator and counter 0.
- Reset asserted mid-operation: abort immediately and asynchronously. No `DONE`.
- Start accepted at edge E0.
  - `BUSY`=1 from after E0 until after edge E(WIDTH+1): WIDTH+1 cycles.
  - After E(WIDTH+1): `HI`/`LO` hold the new result, `DONE`=1 for exactly one cycle, `BUSY`=0.
  - WIDTH=32: result visible 33 edges after the accepting edge.
- A new `START` is accepted in the `DONE` cycle, giving back-to-back operations with no bubble.
- MTHI/MTLO: value visible on `HI`/`LO` the cycle after the accepting edge.
- `BUSY` and `DONE` are registered outputs. No combinational path from inputs to outputs.

## Test plan
- Reset then idle: `RST` low mid-MULT at iteration 10 → `BUSY`=0, `HI`=`LO`=0, no `DONE` pulse after release.
- MULT, A=0xFFFFFFFE (−2), B=0x00000003 → after 33 edges: HI=0xFFFFFFFF, LO=0xFFFFFFFA, one `DONE` pulse. MULTU with the same operands → HI=0x00000002, LO=0xFFFFFFFA.
- DIV, A=0xFFFFFFF9 (−7), B=2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU, A=7, B=0 → LO=0xFFFFFFFF, HI=0x00000007. DIV, A=0x80000000, B=0xFFFFFFFF → LO=0x80000000, HI=0.
- Handshake: MTHI B=0x1234 while `BUSY` → ignored and HI unchanged. MTLO B=0x55 when idle → LO=0x55 next cycle. DIVU 100/7 issued in the `DONE` cycle of the prior op → LO=14, HI=2.
- `FLUSH` at CALC iteration 5 of MULTU 3×5 → IDLE next edge, HI/LO keep prior values, no `DONE`. A following MULTU 3×5 → LO=15, HI=0.
- WIDTH=8 instance: MULT 0x80×0x80 → HI=0x40, LO=0x00 after 9 edges. DIV 0x81/0x03 → LO=0xD6, HI=0xFF.
